// File: rtl/ltl_nfa_engine.sv
// Runtime-programmable homogeneous NFA engine (stride 1) for LTL runtime monitors.
// STE tables are loaded while halted; report activity is aggregated into sticky flags, a count and a first-hit capture.
module ltl_nfa_engine #(
  parameter int NUM_STATES = 16,
  parameter int SYM_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [SYM_W-1:0]      symbols,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_sel,
  input  logic [4:0]            cfg_state,
  input  logic [2:0]            cfg_word,
  input  logic [31:0]           cfg_wdata,
  output logic                  cfg_err,
  output logic [NUM_STATES-1:0] active_state,
  output logic [NUM_STATES-1:0] report,
  output logic                  report_any,
  output logic [NUM_STATES-1:0] report_sticky,
  output logic [CNT_W-1:0]      report_count,
  output logic                  first_report_valid,
  output logic [CNT_W-1:0]      first_report_cycle,
  input  logic                  report_clr
);

  localparam int MW = 1 << SYM_W;
  localparam int NWORDS = MW / 32;
  localparam logic [5:0] NS_L = 6'(NUM_STATES);
  localparam logic [3:0] NW_L = 4'(NWORDS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MW-1:0]         r_match [NUM_STATES];
  logic [NUM_STATES-1:0] r_pred  [NUM_STATES];
  logic [1:0]            r_start [NUM_STATES];
  logic [NUM_STATES-1:0] r_ren;
  logic [NUM_STATES-1:0] r_active;
  logic [NUM_STATES-1:0] r_sticky;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_first;
  logic [CNT_W-1:0]      r_cyc;
  logic                  r_first_vld;
  logic                  r_sod;
  logic                  r_cfg_err;

  logic                  w_state_ok;
  logic                  w_word_ok;
  logic                  w_cfg_ok;
  logic [NUM_STATES-1:0] w_en;
  logic [NUM_STATES-1:0] w_next;
  logic [NUM_STATES-1:0] w_next_rep;
  logic                  w_hit;

  // The word index only matters for match-bitmap writes.
  assign w_state_ok = ({1'b0, cfg_state} < NS_L);
  assign w_word_ok  = (cfg_sel != 2'd0) || ({1'b0, cfg_word} < NW_L);
  assign w_cfg_ok   = cfg_we & ~run & w_state_ok & w_word_ok;

  // Per-STE enable from predecessors/start type, then symbol match.
  always_comb begin
    w_en   = '0;
    w_next = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      w_en[i]   = (|(r_active & r_pred[i])) | (r_start[i] == 2'd2) |
                  ((r_start[i] == 2'd1) & r_sod);
      w_next[i] = w_en[i] & r_match[i][symbols];
    end
  end

  assign w_next_rep = w_next & r_ren;
  assign w_hit      = |w_next_rep;

  // Configuration tables and the write-reject pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        r_match[s] <= '0;
        r_pred[s]  <= '0;
        r_start[s] <= 2'd0;
      end
      r_ren     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we & ~w_cfg_ok;
      if (w_cfg_ok) begin
        for (int s = 0; s < NUM_STATES; s++) begin
          if (cfg_state == 5'(s)) begin
            case (cfg_sel)
              2'd0: begin
                for (int w = 0; w < NWORDS; w++) begin
                  if (cfg_word == 3'(w)) r_match[s][w*32 +: 32] <= cfg_wdata;
                end
              end
              2'd1:    r_pred[s]  <= cfg_wdata[NUM_STATES-1:0];
              2'd2:    r_start[s] <= cfg_wdata[1:0];
              2'd3:    r_ren[s]   <= cfg_wdata[0];
              default: r_ren[s]   <= r_ren[s];
            endcase
          end
        end
      end
    end
  end

  // Automaton state, start-of-data flag and symbol index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= '0;
      r_sod    <= 1'b1;
      r_cyc    <= '0;
    end else if (run) begin
      r_active <= w_next;
      r_sod    <= 1'b0;
      r_cyc    <= r_cyc + CNT_W'(1);
    end
  end

  // Report aggregation; a new report overrides a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky    <= '0;
      r_count     <= '0;
      r_first     <= '0;
      r_first_vld <= 1'b0;
    end else if (run && w_hit) begin
      if (report_clr) begin
        r_sticky    <= w_next_rep;
        r_count     <= CNT_W'(1);
        r_first     <= r_cyc;
        r_first_vld <= 1'b1;
      end else begin
        r_sticky <= r_sticky | w_next_rep;
        if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
        if (!r_first_vld) begin
          r_first     <= r_cyc;
          r_first_vld <= 1'b1;
        end
      end
    end else if (report_clr) begin
      r_sticky    <= '0;
      r_count     <= '0;
      r_first     <= '0;
      r_first_vld <= 1'b0;
    end
  end

  assign cfg_err            = r_cfg_err;
  assign active_state       = r_active;
  assign report             = r_active & r_ren;
  assign report_any         = |report;
  assign report_sticky      = r_sticky;
  assign report_count       = r_count;
  assign first_report_valid = r_first_vld;
  assign first_report_cycle = r_first;

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// Randomized bench for ltl_nfa_engine against a set-based reference model.
// A second instance with a 2-bit counter exercises saturation.
module tb_ltl_nfa_engine;
  localparam int NS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  symbols = 8'd0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [4:0]  cfg_state = 5'd0;
  logic [2:0]  cfg_word = 3'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        report_clr = 1'b0;

  logic          a_err, a_any, a_vld;
  logic [NS-1:0] a_act, a_rep, a_sticky;
  logic [15:0]   a_cnt, a_first;
  logic          b_err, b_any, b_vld;
  logic [NS-1:0] b_act, b_rep, b_sticky;
  logic [1:0]    b_cnt, b_first;

  ltl_nfa_engine #(.NUM_STATES(NS), .SYM_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_state(cfg_state), .cfg_word(cfg_word),
    .cfg_wdata(cfg_wdata), .cfg_err(a_err), .active_state(a_act), .report(a_rep),
    .report_any(a_any), .report_sticky(a_sticky), .report_count(a_cnt),
    .first_report_valid(a_vld), .first_report_cycle(a_first), .report_clr(report_clr));

  ltl_nfa_engine #(.NUM_STATES(NS), .SYM_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_state(cfg_state), .cfg_word(cfg_word),
    .cfg_wdata(cfg_wdata), .cfg_err(b_err), .active_state(b_act), .report(b_rep),
    .report_any(b_any), .report_sticky(b_sticky), .report_count(b_cnt),
    .first_report_valid(b_vld), .first_report_cycle(b_first), .report_clr(report_clr));

  always #5 clk = ~clk;

  // Reference model: configuration as sets/tables, run state as plain variables.
  bit            m_match [NS][256];
  logic [NS-1:0] m_pred [NS];
  int            m_start [NS];
  logic [NS-1:0] m_ren;
  logic [NS-1:0] m_act, m_sticky;
  int            m_cnt, m_first, m_cyc;
  bit            m_vld, m_sod, m_err;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < 256; b++) m_match[s][b] = 1'b0;
      m_pred[s]  = '0;
      m_start[s] = 0;
    end
    m_ren = '0; m_act = '0; m_sticky = '0;
    m_cnt = 0; m_first = 0; m_cyc = 0;
    m_vld = 1'b0; m_sod = 1'b1; m_err = 1'b0;
  endfunction

  function automatic void model_step();
    logic [NS-1:0] nxt, repv;
    bit ok, en;
    ok = cfg_we && !run && (int'(cfg_state) < NS) && (cfg_sel != 2'd0 || int'(cfg_word) < 8);
    m_err = cfg_we && !ok;
    if (ok) begin
      case (cfg_sel)
        2'd0: for (int b = 0; b < 32; b++) m_match[cfg_state][int'(cfg_word) * 32 + b] = cfg_wdata[b];
        2'd1: m_pred[cfg_state] = cfg_wdata[NS-1:0];
        2'd2: m_start[cfg_state] = int'(cfg_wdata[1:0]);
        default: m_ren[cfg_state] = cfg_wdata[0];
      endcase
    end
    if (run) begin
      nxt = '0;
      for (int i = 0; i < NS; i++) begin
        en = (m_start[i] == 2) || (m_start[i] == 1 && m_sod);
        for (int j = 0; j < NS; j++) if (m_pred[i][j] && m_act[j]) en = 1'b1;
        nxt[i] = en && m_match[i][symbols];
      end
      repv = nxt & m_ren;
      if (repv != '0) begin
        if (report_clr) begin
          m_sticky = repv; m_cnt = 1; m_first = m_cyc; m_vld = 1'b1;
        end else begin
          m_sticky = m_sticky | repv; m_cnt++;
          if (!m_vld) begin m_first = m_cyc; m_vld = 1'b1; end
        end
      end else if (report_clr) begin
        m_sticky = '0; m_cnt = 0; m_first = 0; m_vld = 1'b0;
      end
      m_act = nxt; m_sod = 1'b0; m_cyc = (m_cyc + 1) & 32'hFFFF;
    end else if (report_clr) begin
      m_sticky = '0; m_cnt = 0; m_first = 0; m_vld = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("active", 32'(a_act), 32'(m_act));
      chk("report", 32'(a_rep), 32'(m_act & m_ren));
      chk("report_any", 32'(a_any), 32'(|(m_act & m_ren)));
      chk("sticky", 32'(a_sticky), 32'(m_sticky));
      chk("count", 32'(a_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
      chk("first_valid", 32'(a_vld), 32'(m_vld));
      chk("first_cycle", 32'(a_first), 32'(m_first & 32'hFFFF));
      chk("cfg_err", 32'(a_err), 32'(m_err));
      chk("sat_count", 32'(b_cnt), 32'((m_cnt > 3) ? 3 : m_cnt));
      chk("sat_first", 32'(b_first), 32'(m_first & 32'h3));
      chk("sat_active", 32'(b_act), 32'(m_act));
    end
  end

  task automatic cyc(input logic r, input logic [7:0] s, input logic c);
    run = r; symbols = s; report_clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [4:0] st, input logic [2:0] wd,
                    input logic [31:0] d, input logic r);
    cfg_we = 1'b1; cfg_sel = sel; cfg_state = st; cfg_word = wd; cfg_wdata = d;
    cyc(r, 8'($urandom), 1'b0);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1; run = 1'b0; report_clr = 1'b0; cfg_we = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_chain();
    wr(2'd0, 5'd0, 3'd2, 32'h0000_0002, 1'b0);
    wr(2'd2, 5'd0, 3'd0, 32'd1, 1'b0);
    wr(2'd0, 5'd1, 3'd2, 32'h0000_0004, 1'b0);
    wr(2'd1, 5'd1, 3'd0, 32'h0000_0001, 1'b0);
    wr(2'd3, 5'd1, 3'd0, 32'd1, 1'b0);
  endtask

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_active", 32'(a_act), 32'h0);
    chk("rst_count", 32'(a_cnt), 32'h0);

    // Chain 0x41 -> 0x42
    cfg_chain();
    cyc(1'b1, 8'h41, 1'b0);
    chk("chain_act0", 32'(a_act), 32'h1);
    cyc(1'b1, 8'h42, 1'b0);
    chk("chain_act1", 32'(a_act), 32'h2);
    chk("chain_cnt", 32'(a_cnt), 32'h1);
    chk("chain_first", 32'(a_first), 32'h1);
    chk("chain_vld", 32'(a_vld), 32'h1);

    // Start-of-data anchoring
    do_reset(); cfg_chain();
    cyc(1'b1, 8'h00, 1'b0); cyc(1'b1, 8'h41, 1'b0); cyc(1'b1, 8'h42, 1'b0);
    chk("sod_cnt", 32'(a_cnt), 32'h0);
    chk("sod_vld", 32'(a_vld), 32'h0);
    do_reset(); cfg_chain();
    cyc(1'b1, 8'h41, 1'b0); cyc(1'b1, 8'h42, 1'b0);
    chk("sod_rearm_first", 32'(a_first), 32'h1);

    // Halt mid-chain
    do_reset(); cfg_chain();
    cyc(1'b1, 8'h41, 1'b0);
    repeat (3) cyc(1'b0, 8'h42, 1'b0);
    chk("halt_act", 32'(a_act), 32'h1);
    cyc(1'b1, 8'h42, 1'b0);
    chk("halt_act_done", 32'(a_act), 32'h2);
    chk("halt_first", 32'(a_first), 32'h1);

    // Config guard: rejected writes leave the table intact
    wr(2'd0, 5'd1, 3'd2, 32'h0, 1'b1);
    chk("guard_run_err", 32'(a_err), 32'h1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("guard_err_pulse", 32'(a_err), 32'h0);
    wr(2'd0, 5'd16, 3'd2, 32'hFFFF_FFFF, 1'b0);
    chk("guard_idx_err", 32'(a_err), 32'h1);
    wr(2'd2, 5'd0, 3'd0, 32'd2, 1'b0);
    cyc(1'b1, 8'h41, 1'b0); cyc(1'b1, 8'h42, 1'b0);
    chk("guard_table_kept", 32'(a_any), 32'h1);

    // All-input self-loop, saturation, clear-vs-report
    do_reset();
    wr(2'd2, 5'd0, 3'd0, 32'd2, 1'b0);
    for (int w = 0; w < 8; w++) wr(2'd0, 5'd0, 3'(w), 32'hFFFF_FFFF, 1'b0);
    wr(2'd1, 5'd0, 3'd0, 32'h1, 1'b0);
    wr(2'd3, 5'd0, 3'd0, 32'd1, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'($urandom), 1'b0);
    chk("all_cnt", 32'(a_cnt), 32'h5);
    chk("all_first", 32'(a_first), 32'h0);
    cyc(1'b1, 8'($urandom), 1'b0);
    chk("sat_cnt3", 32'(b_cnt), 32'h3);
    cyc(1'b1, 8'($urandom), 1'b1);
    chk("clr_win_cnt", 32'(a_cnt), 32'h1);
    chk("clr_win_sticky", 32'(a_sticky), 32'h1);
    chk("clr_win_satcnt", 32'(b_cnt), 32'h1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("clr_halt_cnt", 32'(a_cnt), 32'h0);

    // Randomized configurations and streams
    for (int rnd = 0; rnd < 6; rnd++) begin
      do_reset();
      for (int s = 0; s < NS; s++) begin
        for (int w = 0; w < 8; w++) wr(2'd0, 5'(s), 3'(w), $urandom & $urandom, 1'b0);
        wr(2'd1, 5'(s), 3'd0, $urandom & $urandom, 1'b0);
        wr(2'd2, 5'(s), 3'd0, $urandom, 1'b0);
        wr(2'd3, 5'(s), 3'd0, $urandom, 1'b0);
      end
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 9) == 0)
          wr(2'($urandom), 5'($urandom_range(0, 19)), 3'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));
        else
          cyc(1'($urandom_range(0, 7) != 0), 8'($urandom), 1'($urandom_range(0, 15) == 0));
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ltl_nfa_engine.md
Name: ltl_nfa_engine

Overview:
- Runtime-programmable, homogeneous, stride-1 NFA monitor engine for the LTL runtime-monitor clusters. It replaces per-property generated automata that have hard-wired symbol-match tables and edges.
- Holds NUM_STATES STEs. Each STE has a 2^SYM_W-bit symbol-match bitmap, a predecessor mask, a start type and a report flag, all loaded through a config port while halted.
- Consumes one symbol per run cycle.
- Adds report aggregation: sticky per-state flags, a saturating report counter, and capture of the first-report cycle.

Parameters:
- NUM_STATES, 16, number of STEs (2..32).
- SYM_W, 8, symbol width (5..8). Match bitmap is 2^SYM_W bits per state.
- CNT_W, 16, width of report counter and cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  advance the automaton on this edge; when low, all runtime state holds.
- symbols  in  SYM_W  input symbol, sampled when run=1.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  2  target: 0=match word, 1=predecessor mask, 2=start type, 3=report enable.
- cfg_state  in  5  target STE index.
- cfg_word  in  3  32-bit word index within the match bitmap (cfg_sel=0 only).
- cfg_wdata  in  32  write data.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- active_state  out  NUM_STATES  registered STE activation vector.
- report  out  NUM_STATES  active_state & report_en (combinational from registers).
- report_any  out  1  OR of report.
- report_sticky  out  NUM_STATES  per-state sticky report flags.
- report_count  out  CNT_W  saturating count of run cycles with report_any.
- first_report_valid  out  1  first_report_cycle holds a valid capture.
- first_report_cycle  out  CNT_W  symbol index (0-based) of the first report.
- report_clr  in  1  clear sticky flags, count and first-report capture.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - Match bitmaps, predecessor masks, start types and report_en are 0.
  - cycle counter = 0; sod_pending = 1.
- Config writes are accepted only when run=0. A write is applied on the posedge where cfg_we=1.
  - cfg_sel=0: match[cfg_state][cfg_word*32 +: 32] <= cfg_wdata.
  - cfg_sel=1: pred[cfg_state] <= cfg_wdata[NUM_STATES-1:0]. Bit j set means edge j -> cfg_state.
  - cfg_sel=2: start[cfg_state] <= cfg_wdata[1:0]. 0=none, 1=start-of-data, 2=all-input, 3 is treated as none.
  - cfg_sel=3: report_en[cfg_state] <= cfg_wdata[0].
- Rejected writes: cfg_we with run=1, cfg_state>=NUM_STATES, or cfg_word>=2^SYM_W/32. The write is ignored and cfg_err is high for the next cycle.
- Per posedge with run=1, for each state i:
  - en_i = |(active_state & pred[i]) | (start[i]==2) | (start[i]==1 & sod_pending).
  - active_state[i] <= en_i & match[i][symbols].
  - sod_pending <= 0; cycle counter <= cycle counter + 1 (wraps).
- Latency: symbol k (k = cycle counter value when sampled) affects active_state and report one cycle later.
- Report bookkeeping, per posedge with run=1 where the next active_state & report_en is nonzero:
  - report_sticky |= that vector.
  - report_count increments, saturating at 2^CNT_W-1.
  - If first_report_valid=0: first_report_cycle <= k and first_report_valid <= 1.
- report_clr with no simultaneous report: sticky, count, first_report_valid and first_report_cycle clear to 0.
- report_clr coinciding with a new report: the new report wins.
  - sticky = new vector; count = 1; first capture = k.
- run=0: active_state, counters and sticky flags hold; report_clr still acts.
- Reset mid-run: immediate clear. sod_pending re-arms, so start-of-data STEs fire again on the first run cycle after release.

Test Plan:
- Chain match: S0 start=1, match{0x41}; S1 pred=S0, match{0x42}, report_en=1. Stream 0x41,0x42 -> active_state=0x1 after cycle 0, 0x2 after cycle 1; report_count=1; first_report_cycle=1; first_report_valid=1.
- Start-of-data only: same config, stream 0x00,0x41,0x42 -> no report, count=0. Reset then 0x41,0x42 -> report at cycle 1.
- Self-loop and all-input: S0 start=2, match all, report_en=1; S0 pred includes S0. Stream 5 symbols -> report_any=1 each cycle; count=5; first_report_cycle=0.
- Saturation and clear: CNT_W=2, 6 reporting cycles -> count=3. report_clr on a reporting cycle -> count=1, sticky=report vector.
- Config guard: cfg_we with run=1, or cfg_state=NUM_STATES -> cfg_err pulses once and the table is unchanged (read back via a subsequent match behaviour).
- Halt: run=0 for 3 cycles mid-chain -> active_state and cycle counter frozen; resumption completes the chain with first_report_cycle unaffected by halted cycles.
